// File: rtl/ram_pkg.sv
// Shared constants for the clearable RAM: state encoding and default geometry.
// No logic; imported by the sequencer and the top.
// No flow control.
package ram_pkg;
    localparam int   RAM_WIDTH  = 16;
    localparam int   RAM_ADDR_W = 12;

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_CLEAR   = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_CLEAR = ST_CLEAR
    } clr_state_e;
endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps every address once, writing zero, then idles until the next clear.
// Sweep takes 2**ADDR_W cycles; busy drops the cycle after the last address is written.
// clear is ignored while a sweep is in progress.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    clr_state_e        state;
    clr_state_e        state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (clear) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                // Stop on the last address instead of wrapping back to 0.
                if (cnt == LAST_ADDR) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = S_CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy     = (state == S_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt;
endmodule

// File: rtl/ram_n_clear.sv
// Single-port RAM with a whole-array clear; one shared write port muxed between user and sweep.
// Read latency 1 cycle, write-first on same-address read/write.
// ready low during a sweep: loads are dropped and out is held at 0.
module ram_n_clear
    import ram_pkg::*;
#(
    parameter int WIDTH  = RAM_WIDTH,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  in,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              ready
);
    localparam int DEPTH = 2**ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_acc;
    logic              user_we;
    logic              mem_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_dat;

    ram_clear_seq #(
        .ADDR_W   (ADDR_W)
    ) u_seq (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    // A clear accepted this cycle takes priority over a same-cycle load.
    assign user_acc = !reset && !busy && !clear;
    assign user_we  = user_acc && load;

    always_comb begin
        mem_we  = clr_we | user_we;
        wr_addr = address;
        wr_dat  = in;
        if (clr_we) begin
            wr_addr = clr_addr;
            wr_dat  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!user_acc) begin
            out <= '0;
        end else if (load) begin
            out <= in;
        end else begin
            out <= mem[address];
        end
    end

    assign ready = !busy;
endmodule

// File: tb/tb_ram_n_clear.sv
// Bench for ram_n_clear (WIDTH=16, ADDR_W=4): vector table, hand sequences, random run vs model.
// Inputs change 1 time unit after posedge; outputs sampled at the same point.
module tb_ram_n_clear;
    localparam int W  = 16;
    localparam int AW = 4;
    localparam int D  = 16;

    logic          clk;
    logic          reset;
    logic          load;
    logic [AW-1:0] address;
    logic [W-1:0]  in;
    logic          clear;
    logic [W-1:0]  out;
    logic          ready;

    ram_n_clear #(
        .WIDTH   (W),
        .ADDR_W  (AW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .address (address),
        .in      (in),
        .clear   (clear),
        .out     (out),
        .ready   (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: memory image, cycles left in the current sweep, expected out.
    logic [W-1:0] m_mem [D];
    int           m_left = D;
    logic [W-1:0] m_out  = '0;

    task automatic model_edge(input logic r, input logic c, input logic l,
                              input logic [AW-1:0] a, input logic [W-1:0] d);
        if (r) begin
            m_left = D;
            m_out  = '0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            m_out  = '0;
            if (m_left == 0) begin
                for (int k = 0; k < D; k++) m_mem[k] = '0;
            end
        end else if (c) begin
            m_left = D;
            m_out  = '0;
        end else begin
            if (l) m_mem[a] = d;
            m_out = m_mem[a];
        end
    endtask

    task automatic cyc(input logic r, input logic c, input logic l,
                       input logic [AW-1:0] a, input logic [W-1:0] d);
        reset = r; clear = c; load = l; address = a; in = d;
        @(posedge clk);
        model_edge(r, c, l, a, d);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          r;
        logic          c;
        logic          l;
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        logic [W-1:0]  eo;
        logic          er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic c, input logic l, input logic [AW-1:0] a,
                                input logic [W-1:0] d, input logic [W-1:0] eo, input logic er);
        vec_t v;
        v.r = r; v.c = c; v.l = l; v.a = a; v.d = d; v.eo = eo; v.er = er;
        return v;
    endfunction

    function automatic logic [W-1:0] pat(input int i);
        return 16'hA5A5 ^ W'(i * 16'h1111);
    endfunction

    initial begin
        int n;
        logic [W-1:0] wr [D];

        for (int k = 0; k < D; k++) m_mem[k] = '0;
        reset = 1'b1; clear = 1'b0; load = 1'b0; address = '0; in = '0;

        // Reset, then 16 sweep cycles; ready rises after the 16th edge.
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0));
        for (int i = 1; i < 16; i++)
            tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'(i), 16'hFFFF, 16'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1));
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'(i), 16'h0, 16'h0, 1'b1));
        // Write-first read, then plain read of the same word.
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'd5, 16'hBEEF, 16'hBEEF, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'd5, 16'h0,    16'hBEEF, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'd4, 16'h0,    16'h0,    1'b1));
        // Clear beats a same-cycle load; loads and a repeat clear during the sweep are ignored.
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'd3, 16'h1234, 16'h1234, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'd7, 16'hAAAA, 16'h0,    1'b0));
        for (int k = 1; k <= 16; k++)
            tbl.push_back(mk(1'b0, (k == 4), 1'b1, 4'd3, 16'hFFFF, 16'h0, (k == 16)));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'd3, 16'h0, 16'h0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'd7, 16'h0, 16'h0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'd5, 16'h0, 16'h0, 1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].r, tbl[i].c, tbl[i].l, tbl[i].a, tbl[i].d);
            chk($sformatf("vec%0d_out", i), 32'(out), 32'(tbl[i].eo));
            chk($sformatf("vec%0d_ready", i), 32'(ready), 32'(tbl[i].er));
        end

        // Reset in the middle of a sweep restarts it from address 0.
        cyc(1'b0, 1'b0, 1'b1, 4'd2, 16'h5555);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 16'h0);
        for (int k = 1; k < 8; k++) cyc(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        chk("midrst_ready", 32'(ready), 32'd0);
        n = 0;
        while (!ready && n < 100) begin
            cyc(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
            n++;
        end
        chk("midrst_latency", 32'(n), 32'd16);
        for (int i = 0; i < D; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 4'(i), 16'h0);
            chk($sformatf("midrst_rd%0d", i), 32'(out), 32'd0);
        end

        // Fill all words back to back, read back in descending order.
        for (int i = 0; i < D; i++) begin
            wr[i] = pat(i);
            cyc(1'b0, 1'b0, 1'b1, 4'(i), wr[i]);
        end
        for (int i = D - 1; i >= 0; i--) begin
            cyc(1'b0, 1'b0, 1'b0, 4'(i), 16'h0);
            chk($sformatf("fill_rd%0d", i), 32'(out), 32'(wr[i]));
        end

        // Random traffic checked against the model every cycle.
        for (int t = 0; t < 1500; t++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, D - 1)), 16'($urandom));
            chk($sformatf("rnd%0d_out", t), 32'(out), 32'(m_out));
            chk($sformatf("rnd%0d_ready", t), 32'(ready), 32'(m_left == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
